ula_ctrl: RTL and testbench

Accumulator-based sequencer that drives the 8-bit ULA from the initiator side. It accepts commands over a valid/ready handshake and presents the accumulator and operand on the ULA operand and function ports. It holds them for a fixed number of cycles, captures the ULA result back into the accumulator, and returns that result over a second valid/ready handshake. It sits between the command source (testbench or future instruction decoder) and the combinational `ula` module.

---
 rtl/ula_pkg.sv | 16 +
 rtl/ula_ctrl.sv | 155 +++++++++++++++
 tb/tb_ula_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ULA sequencer: op encodings and controller states.
package ula_pkg;

  // ULA function select, packed as {f1, f2}
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHL = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/ula_ctrl.sv
// Accumulator-based sequencer driving a combinational 8-bit ULA. Accepts a command,
// holds the ULA inputs for ULA_LAT cycles, captures the result into the accumulator
// and returns it over a valid/ready response channel.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int unsigned ULA_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_load,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_opnd,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic       ula_f1,
  output logic       ula_f2,
  input  logic [7:0] ula_r,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic       res_zero,
  output logic [7:0] op_count
);

  // Counter preset on accept; ISSUE lasts until it reaches zero, i.e. ULA_LAT cycles
  localparam logic [3:0] LatInit = 4'(ULA_LAT - 1);

  ctrl_state_e state_q, state_d;

  logic [7:0] acc_q, acc_d;
  logic [7:0] opnd_q, opnd_d;
  logic [1:0] op_q, op_d;
  logic       load_q, load_d;
  logic [3:0] lat_cnt_q, lat_cnt_d;
  logic [7:0] op_count_q, op_count_d;

  logic accept;
  logic lat_done;

  // Commands are only taken in IDLE; anything offered elsewhere is dropped
  assign accept   = (state_q == StIdle) && cmd_valid;
  assign lat_done = (lat_cnt_q == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = cmd_load ? StResp : StIssue;
        end
      end
      StIssue: begin
        if (lat_done) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q      <= 8'd0;
      opnd_q     <= 8'd0;
      op_q       <= 2'd0;
      load_q     <= 1'b0;
      lat_cnt_q  <= 4'd0;
      op_count_q <= 8'd0;
    end else begin
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      op_q       <= op_d;
      load_q     <= load_d;
      lat_cnt_q  <= lat_cnt_d;
      op_count_q <= op_count_d;
    end
  end

  // Datapath next-state: latch command on accept, count down and capture in ISSUE
  always_comb begin
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    op_d       = op_q;
    load_d     = load_q;
    lat_cnt_d  = lat_cnt_q;
    op_count_d = op_count_q;

    if (accept) begin
      load_d = cmd_load;
      op_d   = cmd_op;
      opnd_d = cmd_opnd;
      if (cmd_load) begin
        acc_d = cmd_opnd;
      end else begin
        lat_cnt_d = LatInit;
      end
    end

    if (state_q == StIssue) begin
      if (lat_done) begin
        // load_q is always 0 here; the guard keeps a stray load from counting
        if (!load_q) begin
          acc_d      = ula_r;
          op_count_d = op_count_q + 8'd1;
        end
      end else begin
        lat_cnt_d = lat_cnt_q - 4'd1;
      end
    end
  end

  // Outputs: pure state/register decodes, forced to zero while reset is asserted
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    ula_a     = 8'd0;
    ula_b     = 8'd0;
    ula_f1    = 1'b0;
    ula_f2    = 1'b0;
    res_data  = 8'd0;
    res_zero  = 1'b0;
    op_count  = 8'd0;
    if (rst_n) begin
      cmd_ready = (state_q == StIdle);
      res_valid = (state_q == StResp);
      ula_a     = acc_q;
      ula_b     = opnd_q;
      ula_f1    = op_q[1];
      ula_f2    = op_q[0];
      res_data  = acc_q;
      res_zero  = (acc_q == 8'd0);
      op_count  = op_count_q;
    end
  end

endmodule

// File: tb/tb_ula_ctrl.sv
// Directed bench for ula_ctrl: one instance at ULA_LAT=1 driving a behavioural ULA,
// one at ULA_LAT=3 whose ULA result is steered directly by the bench.
module tb_ula_ctrl;
  import ula_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // ULA_LAT = 1 instance
  logic       rst_n, cmd_valid, cmd_ready, cmd_load, ula_f1, ula_f2;
  logic       res_valid, res_ready, res_zero;
  logic [1:0] cmd_op;
  logic [7:0] cmd_opnd, ula_a, ula_b, ula_r, res_data, op_count;

  // ULA_LAT = 3 instance
  logic       d3_rst_n, d3_cmd_valid, d3_cmd_ready, d3_cmd_load, d3_ula_f1, d3_ula_f2;
  logic       d3_res_valid, d3_res_ready, d3_res_zero;
  logic [1:0] d3_cmd_op;
  logic [7:0] d3_cmd_opnd, d3_ula_a, d3_ula_b, d3_ula_r, d3_res_data, d3_op_count;

  ula_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_load  (cmd_load),
    .cmd_op    (cmd_op),
    .cmd_opnd  (cmd_opnd),
    .ula_a     (ula_a),
    .ula_b     (ula_b),
    .ula_f1    (ula_f1),
    .ula_f2    (ula_f2),
    .ula_r     (ula_r),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .op_count  (op_count)
  );

  ula_ctrl #(.ULA_LAT(3)) dut3 (
    .clk       (clk),
    .rst_n     (d3_rst_n),
    .cmd_valid (d3_cmd_valid),
    .cmd_ready (d3_cmd_ready),
    .cmd_load  (d3_cmd_load),
    .cmd_op    (d3_cmd_op),
    .cmd_opnd  (d3_cmd_opnd),
    .ula_a     (d3_ula_a),
    .ula_b     (d3_ula_b),
    .ula_f1    (d3_ula_f1),
    .ula_f2    (d3_ula_f2),
    .ula_r     (d3_ula_r),
    .res_valid (d3_res_valid),
    .res_ready (d3_res_ready),
    .res_data  (d3_res_data),
    .res_zero  (d3_res_zero),
    .op_count  (d3_op_count)
  );

  // Behavioural ULA: add, sub, shift a left by b, nor
  always_comb begin
    unique case ({ula_f1, ula_f2})
      OP_ADD:  ula_r = ula_a + ula_b;
      OP_SUB:  ula_r = ula_a - ula_b;
      OP_SHL:  ula_r = ula_a << ula_b;
      default: ula_r = ~(ula_a | ula_b);
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one command for a single edge (caller ensures IDLE)
  task automatic send_cmd(input logic ld, input logic [1:0] op, input logic [7:0] opnd);
    cmd_valid = 1'b1;
    cmd_load  = ld;
    cmd_op    = op;
    cmd_opnd  = opnd;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Count extra cycles after the accept edge until res_valid; bounded at 50
  task automatic wait_res(output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    d3_rst_n = 1'b0;
    tick();
    tick();
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL reset_cmd_ready: got %0b expected 0", cmd_ready);
    end
    tests++;
    if (res_valid !== 1'b0 || res_zero !== 1'b0) begin
      fails++; $display("FAIL reset_res: valid %0b zero %0b expected 0 0", res_valid, res_zero);
    end
    tests++;
    if (op_count !== 8'd0 || res_data !== 8'd0 || ula_a !== 8'd0 || ula_b !== 8'd0) begin
      fails++; $display("FAIL reset_data: cnt %0d data %0d a %0d b %0d expected all 0",
                        op_count, res_data, ula_a, ula_b);
    end
    rst_n = 1'b1;
    d3_rst_n = 1'b1;
    tick();
    tests++;
    if (cmd_ready !== 1'b1 || d3_cmd_ready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready: got %0b/%0b expected 1/1",
                        cmd_ready, d3_cmd_ready);
    end
  endtask

  task automatic test_load_add();
    int cyc;
    res_ready = 1'b1;
    send_cmd(1'b1, OP_ADD, 8'd5);
    wait_res(cyc);
    tests++;
    if (cyc !== 0 || res_data !== 8'd5 || res_zero !== 1'b0) begin
      fails++; $display("FAIL load5: lat %0d data %0d zero %0b expected 0 5 0",
                        cyc, res_data, res_zero);
    end
    tick();
    send_cmd(1'b0, OP_ADD, 8'd3);
    tests++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b0 || ula_a !== 8'd5 || ula_b !== 8'd3 ||
        {ula_f1, ula_f2} !== OP_ADD) begin
      fails++; $display("FAIL add3_issue: rdy %0b vld %0b a %0d b %0d f %0d expected 0 0 5 3 0",
                        cmd_ready, res_valid, ula_a, ula_b, {ula_f1, ula_f2});
    end
    wait_res(cyc);
    tests++;
    if (cyc !== 1 || res_data !== 8'd8 || res_zero !== 1'b0 || op_count !== 8'd1) begin
      fails++; $display("FAIL add3: lat %0d data %0d zero %0b cnt %0d expected 1 8 0 1",
                        cyc, res_data, res_zero, op_count);
    end
    tick();
  endtask

  task automatic test_sub_wrap();
    int cyc;
    send_cmd(1'b0, OP_SUB, 8'd8);
    wait_res(cyc);
    tests++;
    if (res_data !== 8'd0 || res_zero !== 1'b1) begin
      fails++; $display("FAIL sub8: data %0d zero %0b expected 0 1", res_data, res_zero);
    end
    tick();
    send_cmd(1'b0, OP_SUB, 8'd1);
    wait_res(cyc);
    tests++;
    if (res_data !== 8'd255 || res_zero !== 1'b0 || op_count !== 8'd3) begin
      fails++; $display("FAIL sub1_wrap: data %0d zero %0b cnt %0d expected 255 0 3",
                        res_data, res_zero, op_count);
    end
    tick();
  endtask

  task automatic test_shl_nor();
    int cyc;
    send_cmd(1'b1, OP_ADD, 8'd3);
    wait_res(cyc);
    tick();
    send_cmd(1'b0, OP_SHL, 8'd2);
    tests++;
    if ({ula_f1, ula_f2} !== OP_SHL) begin
      fails++; $display("FAIL shl_func: got %0d expected 2", {ula_f1, ula_f2});
    end
    wait_res(cyc);
    tests++;
    if (res_data !== 8'd12) begin
      fails++; $display("FAIL shl2: got %0d expected 12", res_data);
    end
    tick();
    send_cmd(1'b0, OP_NOR, 8'd0);
    wait_res(cyc);
    tests++;
    if (res_data !== 8'd243 || op_count !== 8'd5) begin
      fails++; $display("FAIL nor0: data %0d cnt %0d expected 243 5", res_data, op_count);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    res_ready = 1'b0;
    send_cmd(1'b0, OP_ADD, 8'd1);
    wait_res(cyc);
    for (int i = 0; i < 4; i++) begin
      cmd_valid = i[0];
      cmd_load  = 1'b1;
      cmd_opnd  = 8'h55;
      tick();
      tests++;
      if (res_valid !== 1'b1 || res_data !== 8'd244 || cmd_ready !== 1'b0) begin
        fails++; $display("FAIL hold_%0d: vld %0b data %0d rdy %0b expected 1 244 0",
                          i, res_valid, res_data, cmd_ready);
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    tests++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || res_data !== 8'd244 ||
        op_count !== 8'd6) begin
      fails++; $display("FAIL hold_release: vld %0b rdy %0b data %0d cnt %0d expected 0 1 244 6",
                        res_valid, cmd_ready, res_data, op_count);
    end
  endtask

  task automatic test_lat3();
    d3_res_ready = 1'b1;
    d3_cmd_valid = 1'b1;
    d3_cmd_load  = 1'b1;
    d3_cmd_op    = OP_ADD;
    d3_cmd_opnd  = 8'd10;
    tick();
    d3_cmd_valid = 1'b0;
    tests++;
    if (d3_res_valid !== 1'b1 || d3_res_data !== 8'd10) begin
      fails++; $display("FAIL lat3_load: vld %0b data %0d expected 1 10",
                        d3_res_valid, d3_res_data);
    end
    tick();
    d3_ula_r     = 8'h11;
    d3_cmd_valid = 1'b1;
    d3_cmd_load  = 1'b0;
    d3_cmd_opnd  = 8'd1;
    tick();
    d3_cmd_valid = 1'b0;
    tests++;
    if (d3_res_valid !== 1'b0 || d3_cmd_ready !== 1'b0 || d3_ula_a !== 8'd10 ||
        d3_ula_b !== 8'd1) begin
      fails++; $display("FAIL lat3_issue1: vld %0b rdy %0b a %0d b %0d expected 0 0 10 1",
                        d3_res_valid, d3_cmd_ready, d3_ula_a, d3_ula_b);
    end
    d3_ula_r = 8'h22;
    tick();
    tests++;
    if (d3_res_valid !== 1'b0 || d3_ula_a !== 8'd10) begin
      fails++; $display("FAIL lat3_issue2: vld %0b a %0d expected 0 10", d3_res_valid, d3_ula_a);
    end
    d3_ula_r = 8'h33;
    tick();
    tests++;
    if (d3_res_valid !== 1'b0) begin
      fails++; $display("FAIL lat3_issue3: vld %0b expected 0", d3_res_valid);
    end
    tick();
    tests++;
    if (d3_res_valid !== 1'b1 || d3_res_data !== 8'h33 || d3_op_count !== 8'd1) begin
      fails++; $display("FAIL lat3_capture: vld %0b data %0h cnt %0d expected 1 33 1",
                        d3_res_valid, d3_res_data, d3_op_count);
    end
    d3_ula_r = 8'h44;
    tick();
    tests++;
    if (d3_cmd_ready !== 1'b1 || d3_res_data !== 8'h33) begin
      fails++; $display("FAIL lat3_after: rdy %0b data %0h expected 1 33",
                        d3_cmd_ready, d3_res_data);
    end
  endtask

  task automatic test_reset_mid_issue();
    send_cmd(1'b0, OP_ADD, 8'd7);
    rst_n = 1'b0;
    tick();
    tests++;
    if (cmd_ready !== 1'b0 || res_valid !== 1'b0 || res_data !== 8'd0 || res_zero !== 1'b0 ||
        op_count !== 8'd0 || ula_a !== 8'd0 || ula_b !== 8'd0 || ula_f1 !== 1'b0 ||
        ula_f2 !== 1'b0) begin
      fails++; $display("FAIL abort_outputs: rdy %0b vld %0b data %0d zero %0b cnt %0d expected 0s",
                        cmd_ready, res_valid, res_data, res_zero, op_count);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || op_count !== 8'd0 || res_data !== 8'd0) begin
      fails++; $display("FAIL abort_release: vld %0b rdy %0b cnt %0d data %0d expected 0 1 0 0",
                        res_valid, cmd_ready, op_count, res_data);
    end
  endtask

  task automatic test_back_to_back();
    int nres;
    nres      = 0;
    res_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_load  = 1'b0;
    cmd_op    = OP_ADD;
    cmd_opnd  = 8'd1;
    for (int i = 1; i <= 768; i++) begin
      tick();
      if (res_valid) nres++;
      if (i == 765) begin
        tests++;
        if (op_count !== 8'd255 || res_data !== 8'd255) begin
          fails++; $display("FAIL b2b_255: cnt %0d data %0d expected 255 255",
                            op_count, res_data);
        end
      end
    end
    cmd_valid = 1'b0;
    tests++;
    if (nres !== 256 || op_count !== 8'd0 || res_data !== 8'd0 || cmd_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_wrap: res %0d cnt %0d data %0d rdy %0b expected 256 0 0 1",
                        nres, op_count, res_data, cmd_ready);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    cmd_valid    = 1'b0;
    cmd_load     = 1'b0;
    cmd_op       = 2'b00;
    cmd_opnd     = 8'd0;
    res_ready    = 1'b0;
    d3_rst_n     = 1'b0;
    d3_cmd_valid = 1'b0;
    d3_cmd_load  = 1'b0;
    d3_cmd_op    = 2'b00;
    d3_cmd_opnd  = 8'd0;
    d3_res_ready = 1'b0;
    d3_ula_r     = 8'd0;

    test_reset();
    test_load_add();
    test_sub_wrap();
    test_shl_nor();
    test_backpressure();
    test_lat3();
    test_reset_mid_issue();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
